axi_lite_req_arbiter: RTL and testbench
=======================================

AXI_LITE_REQ_ARBITER -- requirements
Module: axi_lite_req_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, AXI-Lite address width.
REQ-002 Parameter DATA_WIDTH, default 32, AXI-Lite data width.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  2  per-requester access request, level, held until done.
REQ-006 we  input  2  per-requester 1=write, 0=read; stable while req high.
REQ-007 addr  input  2*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 wdata  input  2*DATA_WIDTH  packed write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 done  output  2  one-cycle completion pulse to requester i.
REQ-010 rdata  output  DATA_WIDTH  read data, valid while done!=0 for a read.
REQ-011 resp  output  2  captured BRESP/RRESP, valid while done!=0.
REQ-012 m_axi_awaddr, m_axi_awvalid (out); m_axi_awready (in): AW channel, widths ADDR_WIDTH/1/1.
REQ-013 m_axi_wdata, m_axi_wstrb, m_axi_wvalid (out); m_axi_wready (in): W channel, widths DATA_WIDTH/DATA_WIDTH/8/1/1.
REQ-014 m_axi_bresp, m_axi_bvalid (in); m_axi_bready (out): B channel, widths 2/1/1.
REQ-015 m_axi_araddr, m_axi_arvalid (out); m_axi_arready (in): AR channel, widths ADDR_WIDTH/1/1.
REQ-016 m_axi_rdata, m_axi_rresp, m_axi_rvalid (in); m_axi_rready (out): R channel, widths DATA_WIDTH/2/1/1.

Function
REQ-017 FSM states IDLE, WRITE, WRESP, READ, RDATA, DONE; one transaction in flight at a time.
REQ-018 Arbitration in IDLE only: single req wins; both high -> requester not granted last wins (round-robin); last-grant pointer resets to 1 so requester 0 wins first tie.
REQ-019 On grant, latch owner, we, addr, wdata in same edge; go to WRITE if we=1, else READ.
REQ-020 WRITE: awvalid and wvalid both asserted on entry; each deasserts independently at its own handshake edge; leave for WRESP once both handshakes done (same or different cycles).
REQ-021 m_axi_wstrb SHALL be all ones; awaddr/wdata/araddr driven from latched values, stable while valid high.
REQ-022 WRESP: bready=1; on bvalid&bready capture bresp, go to DONE.
REQ-023 READ: arvalid=1 until arready handshake, then RDATA with rready=1; on rvalid&rready capture rdata and rresp, go to DONE.
REQ-024 DONE: done[owner]=1 for exactly one cycle, rdata/resp held; next state IDLE; update last-grant pointer to owner.
REQ-025 req sampled only in IDLE; req drop mid-transaction SHALL NOT abort; bus sequence completes, done still pulses.
REQ-026 No valid deasserted before its handshake; no new AW/AR issued before prior B/R accepted.
REQ-027 SLVERR/DECERR returned unmodified on resp; no retry.

Reset
REQ-028 rst_n low: state IDLE, all valid/ready outputs 0, done=0, rdata=0, resp=0, pointer=1, latches 0, immediately and independent of clk.
REQ-029 Reset mid-transaction abandons it without done pulse; first grant after release follows REQ-018.

Verification
REQ-030 Single write: req=01, we=01, addr0=0x4, wdata0=0xDEADBEEF, slave ready high -> one AW+W handshake, awaddr=0x4, wstrb=0xF, done=01 one cycle, resp=00.
REQ-031 Single read: req=10, we=00, addr1=0x8, slave returns 0x12345678 -> araddr=0x8, done=10, rdata=0x12345678.
REQ-032 Contention: req=11 held after reset -> grants 0,1,0,1 strictly alternating, no overlapping transactions.
REQ-033 Skewed handshakes: wready delayed 3 cycles after awready -> wvalid held, bready only after both handshakes, one done.
REQ-034 Error: slave bresp=10 -> resp=10 with done pulse, FSM returns to IDLE.
REQ-035 Reset asserted in RDATA -> rready/done 0 at once; after release read from req=01 completes normally.

Source files
------------

// File: rtl/axi_lite_req_arbiter.sv
// Two-requester AXI-Lite master: round-robin grant in IDLE, then one full
// write (AW+W then B) or read (AR then R) transaction before a done pulse.
module axi_lite_req_arbiter #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [1:0]                req,
   input  logic [1:0]                we,
   input  logic [2*ADDR_WIDTH-1:0]   addr,
   input  logic [2*DATA_WIDTH-1:0]   wdata,
   output logic [1:0]                done,
   output logic [DATA_WIDTH-1:0]     rdata,
   output logic [1:0]                resp,
   output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
   output logic                      m_axi_awvalid,
   input  logic                      m_axi_awready,
   output logic [DATA_WIDTH-1:0]     m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
   output logic                      m_axi_wvalid,
   input  logic                      m_axi_wready,
   input  logic [1:0]                m_axi_bresp,
   input  logic                      m_axi_bvalid,
   output logic                      m_axi_bready,
   output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
   output logic                      m_axi_arvalid,
   input  logic                      m_axi_arready,
   input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
   input  logic [1:0]                m_axi_rresp,
   input  logic                      m_axi_rvalid,
   output logic                      m_axi_rready,
   output logic [2:0]                o_dbg_state
);

   // IDLE encodes as 0 so the debug port reads 0 out of reset.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_WRESP = 3'd2,
      S_READ  = 3'd3,
      S_RDATA = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic                  r_owner;
   logic                  r_we;
   logic                  r_last;
   logic                  r_aw_pend;
   logic                  r_w_pend;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [1:0]            r_resp;

   logic                  w_grant_valid;
   logic                  w_grant_idx;
   logic [ADDR_WIDTH-1:0] w_grant_addr;
   logic [DATA_WIDTH-1:0] w_grant_wdata;

   // On a tie the requester that was not served last wins.
   always_comb begin
      w_grant_valid = 1'b0;
      w_grant_idx   = 1'b0;
      case (req)
         2'b01: begin w_grant_valid = 1'b1; w_grant_idx = 1'b0;    end
         2'b10: begin w_grant_valid = 1'b1; w_grant_idx = 1'b1;    end
         2'b11: begin w_grant_valid = 1'b1; w_grant_idx = ~r_last; end
         default: ;
      endcase
   end

   assign w_grant_addr  = w_grant_idx ? addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr[ADDR_WIDTH-1:0];
   assign w_grant_wdata = w_grant_idx ? wdata[2*DATA_WIDTH-1:DATA_WIDTH] : wdata[DATA_WIDTH-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Handshakes: a beat transfers on a rising edge where valid and ready are
   // both high; a valid is never withdrawn before its transfer.
   always_comb begin
      w_next        = r_state;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_bready  = 1'b0;
      m_axi_arvalid = 1'b0;
      m_axi_rready  = 1'b0;
      done          = 2'b00;
      case (r_state)
         S_IDLE:  if (w_grant_valid) w_next = we[w_grant_idx] ? S_WRITE : S_READ;
         S_WRITE: begin
            m_axi_awvalid = r_aw_pend;
            m_axi_wvalid  = r_w_pend;
            if ((!r_aw_pend || m_axi_awready) && (!r_w_pend || m_axi_wready))
               w_next = S_WRESP;
         end
         S_WRESP: begin
            m_axi_bready = r_we;
            if (m_axi_bvalid) w_next = S_DONE;
         end
         S_READ: begin
            m_axi_arvalid = 1'b1;
            if (m_axi_arready) w_next = S_RDATA;
         end
         S_RDATA: begin
            m_axi_rready = !r_we;
            if (m_axi_rvalid) w_next = S_DONE;
         end
         S_DONE: begin
            done   = r_owner ? 2'b10 : 2'b01;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_owner   <= 1'b0;
         r_we      <= 1'b0;
         r_last    <= 1'b1;
         r_aw_pend <= 1'b0;
         r_w_pend  <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_rdata   <= '0;
         r_resp    <= 2'b00;
      end else begin
         case (r_state)
            S_IDLE: if (w_grant_valid) begin
               r_owner   <= w_grant_idx;
               r_we      <= we[w_grant_idx];
               r_addr    <= w_grant_addr;
               r_wdata   <= w_grant_wdata;
               r_aw_pend <= we[w_grant_idx];
               r_w_pend  <= we[w_grant_idx];
            end
            S_WRITE: begin
               if (m_axi_awready) r_aw_pend <= 1'b0;
               if (m_axi_wready)  r_w_pend  <= 1'b0;
            end
            S_WRESP: if (m_axi_bvalid) r_resp <= m_axi_bresp;
            S_RDATA: if (m_axi_rvalid) begin
               r_rdata <= m_axi_rdata;
               r_resp  <= m_axi_rresp;
            end
            S_DONE:  r_last <= r_owner;
            default: ;
         endcase
      end
   end

   assign m_axi_awaddr = r_addr;
   assign m_axi_araddr = r_addr;
   assign m_axi_wdata  = r_wdata;
   assign m_axi_wstrb  = '1;
   assign rdata        = r_rdata;
   assign resp         = r_resp;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// Randomized scoreboard bench: requester queues feed the DUT, a memory-backed
// AXI-Lite slave answers, and a reference arbiter/memory model predicts done order and data.
module tb_axi_lite_req_arbiter;
   localparam int AW = 4;
   localparam int DW = 32;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } txn_t;

   typedef struct packed {
      logic [1:0]    done;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
      logic [1:0]    resp;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [1:0]      req = '0;
   logic [1:0]      we = '0;
   logic [2*AW-1:0] addr = '0;
   logic [2*DW-1:0] wdata = '0;
   logic [1:0]      done;
   logic [DW-1:0]   rdata;
   logic [1:0]      resp;
   logic [AW-1:0]   m_axi_awaddr;
   logic            m_axi_awvalid;
   logic            m_axi_awready = 1'b0;
   logic [DW-1:0]   m_axi_wdata;
   logic [DW/8-1:0] m_axi_wstrb;
   logic            m_axi_wvalid;
   logic            m_axi_wready = 1'b0;
   logic [1:0]      m_axi_bresp = '0;
   logic            m_axi_bvalid = 1'b0;
   logic            m_axi_bready;
   logic [AW-1:0]   m_axi_araddr;
   logic            m_axi_arvalid;
   logic            m_axi_arready = 1'b0;
   logic [DW-1:0]   m_axi_rdata = '0;
   logic [1:0]      m_axi_rresp = '0;
   logic            m_axi_rvalid = 1'b0;
   logic            m_axi_rready;
   logic [2:0]      dbg_state;

   axi_lite_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .done(done), .rdata(rdata), .resp(resp),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
      .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
      .m_axi_rready(m_axi_rready), .o_dbg_state(dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   int            tests = 0;
   int            fails = 0;
   txn_t          drv_q0[$];
   txn_t          drv_q1[$];
   exp_t          exp_q[$];
   logic [DW-1:0] ref_mem[16];
   logic [DW-1:0] slv_mem[16];
   int            ref_last = 1;
   int            k_aw = -1, k_w = -1, k_b = -1, k_ar = -1, k_r = -1;
   int            n_aw = 0, n_w = 0, n_ar = 0, n_done = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [1:0] resp_for(input logic [AW-1:0] a);
      if (a == 4'hF)      return 2'b11;
      else if (a == 4'hE) return 2'b10;
      else                return 2'b00;
   endfunction

   function automatic int pick(input int k);
      return (k < 0) ? int'($urandom_range(0, 3)) : k;
   endfunction

   function automatic txn_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      txn_t t;
      t.we = w; t.addr = a; t.wdata = d;
      return t;
   endfunction

   // Reference model: round-robin over non-empty requester queues, flat memory.
   task automatic schedule(input txn_t b0[$], input txn_t b1[$]);
      txn_t t;
      exp_t e;
      int   w;
      foreach (b0[k]) drv_q0.push_back(b0[k]);
      foreach (b1[k]) drv_q1.push_back(b1[k]);
      while (b0.size() > 0 || b1.size() > 0) begin
         if (b0.size() == 0)      w = 1;
         else if (b1.size() == 0) w = 0;
         else                     w = (ref_last == 1) ? 0 : 1;
         ref_last = w;
         if (w == 0) begin t = b0[0]; b0.delete(0); end
         else        begin t = b1[0]; b1.delete(0); end
         e.done  = (w == 0) ? 2'b01 : 2'b10;
         e.we    = t.we;
         e.addr  = t.addr;
         e.wdata = t.wdata;
         e.resp  = resp_for(t.addr);
         e.rdata = '0;
         if (t.we) begin
            if (e.resp == 2'b00) ref_mem[t.addr] = t.wdata;
         end else begin
            e.rdata = ref_mem[t.addr];
         end
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((exp_q.size() > 0 || drv_q0.size() > 0 || drv_q1.size() > 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (n >= 3000) begin
         fails++;
         $display("FAIL %s: timeout with %0d responses outstanding, 0 required", name, exp_q.size());
         exp_q.delete(); drv_q0.delete(); drv_q1.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   // driver: hold each requester's head transaction until its done pulse
   initial begin
      forever begin
         @(negedge clk);
         if (done[0] && drv_q0.size() > 0) drv_q0.delete(0);
         if (done[1] && drv_q1.size() > 0) drv_q1.delete(0);
         req[0] = (drv_q0.size() > 0);
         req[1] = (drv_q1.size() > 0);
         if (drv_q0.size() > 0) begin
            we[0] = drv_q0[0].we; addr[AW-1:0] = drv_q0[0].addr; wdata[DW-1:0] = drv_q0[0].wdata;
         end
         if (drv_q1.size() > 0) begin
            we[1] = drv_q1[0].we; addr[2*AW-1:AW] = drv_q1[0].addr; wdata[2*DW-1:DW] = drv_q1[0].wdata;
         end
      end
   end

   // scoreboard monitor
   logic [1:0] prev_done = 2'b00;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (prev_done != 2'b00) check("done_one_cycle", {62'd0, done}, 64'd0);
         if (done != 2'b00) begin
            n_done++;
            if (exp_q.size() == 0) check("unexpected_done", {62'd0, done}, 64'd0);
            else begin
               e = exp_q[0];
               exp_q.delete(0);
               check("done_vec", {62'd0, done}, {62'd0, e.done});
               check("resp", {62'd0, resp}, {62'd0, e.resp});
               if (!e.we) check("rdata", {32'd0, rdata}, {32'd0, e.rdata});
            end
         end
         prev_done = done;
      end
   end

   // memory-backed slave; inputs change only on negedges
   initial begin
      logic          got_aw, got_w, got_ar, aw_fire, w_fire, b_fire, ar_fire, r_fire;
      int            aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
      logic [AW-1:0] cap_awaddr, cap_araddr;
      logic [DW-1:0] cap_wdata;
      got_aw = 0; got_w = 0; got_ar = 0;
      aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
      aw_cnt = -1; w_cnt = -1; b_cnt = -1; ar_cnt = -1; r_cnt = -1;
      cap_awaddr = '0; cap_araddr = '0; cap_wdata = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_arready = 0; m_axi_rvalid = 0;
            got_aw = 0; got_w = 0; got_ar = 0;
            aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
            aw_cnt = -1; w_cnt = -1; b_cnt = -1; ar_cnt = -1; r_cnt = -1;
            continue;
         end
         if (aw_fire) begin m_axi_awready = 0; got_aw = 1; aw_fire = 0; n_aw++; end
         if (w_fire)  begin m_axi_wready = 0; got_w = 1; w_fire = 0; n_w++; end
         if (b_fire)  begin m_axi_bvalid = 0; got_aw = 0; got_w = 0; b_fire = 0; end
         if (ar_fire) begin m_axi_arready = 0; got_ar = 1; ar_fire = 0; n_ar++; end
         if (r_fire)  begin m_axi_rvalid = 0; got_ar = 0; r_fire = 0; end

         if (aw_cnt >= 0) check("awvalid_held", {63'd0, m_axi_awvalid}, 64'd1);
         if (w_cnt >= 0)  check("wvalid_held", {63'd0, m_axi_wvalid}, 64'd1);
         if (ar_cnt >= 0) check("arvalid_held", {63'd0, m_axi_arvalid}, 64'd1);
         if (got_aw) check("no_aw_reissue", {63'd0, m_axi_awvalid}, 64'd0);
         if (got_ar) check("no_ar_reissue", {63'd0, m_axi_arvalid}, 64'd0);
         if (m_axi_bready) check("bready_after_both", {63'd0, got_aw & got_w}, 64'd1);

         if (m_axi_awvalid && !got_aw && !aw_fire) begin
            if (aw_cnt < 0) aw_cnt = pick(k_aw);
            if (aw_cnt == 0) begin
               m_axi_awready = 1; aw_fire = 1; aw_cnt = -1; cap_awaddr = m_axi_awaddr;
               if (exp_q.size() > 0) begin
                  check("aw_for_write", 64'd1, {63'd0, exp_q[0].we});
                  check("awaddr", {60'd0, m_axi_awaddr}, {60'd0, exp_q[0].addr});
               end
            end else aw_cnt--;
         end
         if (m_axi_wvalid && !got_w && !w_fire) begin
            if (w_cnt < 0) w_cnt = pick(k_w);
            if (w_cnt == 0) begin
               m_axi_wready = 1; w_fire = 1; w_cnt = -1; cap_wdata = m_axi_wdata;
               check("wstrb", {60'd0, m_axi_wstrb}, 64'hF);
               if (exp_q.size() > 0) check("wdata", {32'd0, m_axi_wdata}, {32'd0, exp_q[0].wdata});
            end else w_cnt--;
         end
         if (got_aw && got_w && !m_axi_bvalid && !b_fire) begin
            if (b_cnt < 0) b_cnt = pick(k_b);
            if (b_cnt == 0) begin
               m_axi_bvalid = 1; m_axi_bresp = resp_for(cap_awaddr); b_cnt = -1;
               if (m_axi_bresp == 2'b00) slv_mem[cap_awaddr] = cap_wdata;
            end else b_cnt--;
         end
         if (m_axi_bvalid && m_axi_bready && !b_fire) b_fire = 1;

         if (m_axi_arvalid && !got_ar && !ar_fire) begin
            if (ar_cnt < 0) ar_cnt = pick(k_ar);
            if (ar_cnt == 0) begin
               m_axi_arready = 1; ar_fire = 1; ar_cnt = -1; cap_araddr = m_axi_araddr;
               if (exp_q.size() > 0) begin
                  check("ar_for_read", 64'd0, {63'd0, exp_q[0].we});
                  check("araddr", {60'd0, m_axi_araddr}, {60'd0, exp_q[0].addr});
               end
            end else ar_cnt--;
         end
         if (got_ar && !m_axi_rvalid && !r_fire) begin
            if (r_cnt < 0) r_cnt = pick(k_r);
            if (r_cnt == 0) begin
               m_axi_rvalid = 1; m_axi_rdata = slv_mem[cap_araddr];
               m_axi_rresp = resp_for(cap_araddr); r_cnt = -1;
            end else r_cnt--;
         end
         if (m_axi_rvalid && m_axi_rready && !r_fire) r_fire = 1;

         if (m_axi_awvalid || m_axi_arvalid)
            check("no_overlap", {63'd0, m_axi_awvalid & m_axi_arvalid}, 64'd0);
      end
   end

   // main sequence
   initial begin
      txn_t b0[$];
      txn_t b1[$];
      int   n;
      for (int i = 0; i < 16; i++) begin ref_mem[i] = '0; slv_mem[i] = '0; end

      rst_n = 0;
      repeat (3) @(negedge clk);
      check("rst_awvalid", {63'd0, m_axi_awvalid}, 64'd0);
      check("rst_wvalid", {63'd0, m_axi_wvalid}, 64'd0);
      check("rst_bready", {63'd0, m_axi_bready}, 64'd0);
      check("rst_arvalid", {63'd0, m_axi_arvalid}, 64'd0);
      check("rst_rready", {63'd0, m_axi_rready}, 64'd0);
      check("rst_done", {62'd0, done}, 64'd0);
      check("rst_rdata", {32'd0, rdata}, 64'd0);
      check("rst_resp", {62'd0, resp}, 64'd0);
      check("rst_state", {61'd0, dbg_state}, 64'd0);
      rst_n = 1;
      @(negedge clk);

      // single write, slave always ready
      k_aw = 0; k_w = 0; k_b = 0; k_ar = 0; k_r = 0;
      b0.delete(); b1.delete();
      b0.push_back(mk(1'b1, 4'h4, 32'hDEADBEEF));
      schedule(b0, b1);
      wait_idle("single_write");
      check("single_write_aw_count", n_aw, 1);
      check("single_write_w_count", n_w, 1);
      check("single_write_done_count", n_done, 1);

      // single read from requester 1
      ref_mem[8] = 32'h12345678; slv_mem[8] = 32'h12345678;
      b0.delete(); b1.delete();
      b1.push_back(mk(1'b0, 4'h8, 32'h0));
      schedule(b0, b1);
      wait_idle("single_read");
      check("single_read_ar_count", n_ar, 1);

      // contention with random slave timing
      k_aw = -1; k_w = -1; k_b = -1; k_ar = -1; k_r = -1;
      b0.delete(); b1.delete();
      for (int i = 0; i < 4; i++) begin
         b0.push_back(mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 13)), $urandom));
         b1.push_back(mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 13)), $urandom));
      end
      schedule(b0, b1);
      wait_idle("contention");

      // W handshake three cycles after AW
      k_aw = 0; k_w = 3;
      b0.delete(); b1.delete();
      b0.push_back(mk(1'b1, 4'h2, 32'hCAFEF00D));
      b1.push_back(mk(1'b1, 4'h3, 32'h0BADF00D));
      schedule(b0, b1);
      wait_idle("skewed_write");

      // error responses pass through unmodified
      k_aw = -1; k_w = -1;
      b0.delete(); b1.delete();
      b0.push_back(mk(1'b1, 4'hE, 32'h11111111));
      b1.push_back(mk(1'b0, 4'hF, 32'h0));
      b1.push_back(mk(1'b0, 4'h2, 32'h0));
      schedule(b0, b1);
      wait_idle("error_resp");

      // random rounds
      for (int r = 0; r < 8; r++) begin
         b0.delete(); b1.delete();
         n = $urandom_range(0, 4);
         for (int i = 0; i < n; i++) b0.push_back(mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom));
         n = $urandom_range(0, 4);
         for (int i = 0; i < n; i++) b1.push_back(mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom));
         schedule(b0, b1);
         wait_idle("random_round");
      end

      // reset while waiting for read data
      k_ar = 0; k_r = 20;
      drv_q1.push_back(mk(1'b0, 4'h3, 32'h0));
      n = 0;
      while (!m_axi_rready && n < 100) begin @(negedge clk); n++; end
      check("reached_rdata", {63'd0, m_axi_rready}, 64'd1);
      rst_n = 0;
      #1;
      check("midrst_rready", {63'd0, m_axi_rready}, 64'd0);
      check("midrst_done", {62'd0, done}, 64'd0);
      check("midrst_arvalid", {63'd0, m_axi_arvalid}, 64'd0);
      drv_q0.delete(); drv_q1.delete(); exp_q.delete();
      ref_last = 1;
      repeat (2) @(negedge clk);
      rst_n = 1;
      k_ar = -1; k_r = -1;
      b0.delete(); b1.delete();
      b0.push_back(mk(1'b0, 4'h4, 32'h0));
      b1.push_back(mk(1'b1, 4'h5, 32'h55AA55AA));
      schedule(b0, b1);
      wait_idle("after_reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
